serial_add16: RTL and testbench



---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add16_if.sv | 22 ++
 rtl/RCA4.sv | 20 ++
 rtl/serial_add16.sv | 101 ++++++++++
 tb/tb_serial_add16.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package serial_add_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   localparam int unsigned SLICE_W = 4;

   // Slice counter width; a single-nibble build still needs one bit.
   function automatic int unsigned cnt_w(input int unsigned nibbles);
      return (nibbles > 1) ? $clog2(nibbles) : 1;
   endfunction

endpackage

// File: rtl/serial_add16_if.sv
// Operand/result bus of serial_add16. Carries ovf only when SERIAL_ADD_OVF_EN is defined.
interface serial_add16_if #(
   parameter int unsigned NIBBLES = 4
);
   logic                   start;
   logic [4*NIBBLES-1:0]   a;
   logic [4*NIBBLES-1:0]   b;
   logic                   cin;
   logic                   busy;
   logic                   done;
   logic [4*NIBBLES-1:0]   sum;
   logic                   cout;
`ifdef SERIAL_ADD_OVF_EN
   logic                   ovf;

   modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/RCA4.sv
// 4-bit ripple-carry adder used as the per-cycle slice of serial_add16.
module RCA4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic [3:0] sum,
   input  logic       cin,
   output logic       cout
);
   logic c;

   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end
endmodule

// File: rtl/serial_add16.sv
// Wide adder built from one RCA4: one nibble per cycle, carry chained through c_q.
// Optional signed-overflow output enabled by SERIAL_ADD_OVF_EN.
module serial_add16
   import serial_add_pkg::*;
#(
   parameter int unsigned NIBBLES = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_add16_if.slave  bus
);
   localparam int unsigned W  = SLICE_W * NIBBLES;
   localparam int unsigned CW = cnt_w(NIBBLES);

   state_e          state_q;
   logic [W-1:0]    a_sh, b_sh, s_sh, sum_q;
   logic [CW-1:0]   cnt;
   logic            c_q, cout_q, busy_q, done_q;
`ifdef SERIAL_ADD_OVF_EN
   logic            ovf_q;
`endif

   logic [SLICE_W-1:0] rca_sum;
   logic               rca_cout;
   logic               last;
   logic [W-1:0]       s_next;

   RCA4 u_rca (
      .a    (a_sh[SLICE_W-1:0]),
      .b    (b_sh[SLICE_W-1:0]),
      .sum  (rca_sum),
      .cin  (c_q),
      .cout (rca_cout)
   );

   assign last   = (cnt == CW'(NIBBLES - 1));
   // New nibble enters at the top; after NIBBLES shifts the LSB nibble sits at [3:0].
   assign s_next = (s_sh >> SLICE_W) | (W'(rca_sum) << (W - SLICE_W));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         sum_q   <= '0;
         cnt     <= '0;
         c_q     <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE, DONE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_sh    <= bus.a;
                  b_sh    <= bus.b;
                  c_q     <= bus.cin;
                  cnt     <= '0;
                  s_sh    <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               s_sh <= s_next;
               c_q  <= rca_cout;
               a_sh <= a_sh >> SLICE_W;
               b_sh <= b_sh >> SLICE_W;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  sum_q   <= s_next;
                  cout_q  <= rca_cout;
`ifdef SERIAL_ADD_OVF_EN
                  ovf_q   <= (a_sh[SLICE_W-1] == b_sh[SLICE_W-1]) &&
                             (rca_sum[SLICE_W-1] != a_sh[SLICE_W-1]);
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign bus.ovf  = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add16.sv
// Self-checking bench for serial_add16 (NIBBLES=4): vector table, scoreboard, corner sequences.
module tb_serial_add16;
   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } vec_t;

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   n_done = 0;
   int   cyc = 0;
   exp_t sb[$];

   serial_add16_if #(.NIBBLES(4)) bus ();

   serial_add16 #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic cin);
      exp_t       e;
      logic [16:0] r;
      r      = {1'b0, a} + {1'b0, b} + {16'd0, cin};
      e.sum  = r[15:0];
      e.cout = r[16];
      e.ovf  = (a[15] == b[15]) && (r[15] != a[15]);
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest accepted operation.
   always @(negedge clk) begin
      if (rst_n && bus.done) begin
         exp_t e;
         n_done++;
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sum", {16'd0, bus.sum}, {16'd0, e.sum});
            chk("cout", {31'd0, bus.cout}, {31'd0, e.cout});
`ifdef SERIAL_ADD_OVF_EN
            chk("ovf", {31'd0, bus.ovf}, {31'd0, e.ovf});
`endif
         end
      end
   end

   // One add with latency checks; optionally pokes start with other operands mid-RUN.
   task automatic do_add(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input exp_t e, input bit poke);
      int d0;
      bus.a     = va;
      bus.b     = vb;
      bus.cin   = vc;
      bus.start = 1'b1;
      @(posedge clk);
      sb.push_back(e);
      #1;
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      bus.cin   = 1'($urandom);
      d0 = n_done;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("busy_run", {31'd0, bus.busy}, 32'd1);
         chk("done_early", {31'd0, bus.done}, 32'd0);
         if (poke && k == 0) begin
            bus.a = 16'h1111; bus.b = 16'h2222; bus.start = 1'b1;
         end
         if (poke && k == 1) bus.start = 1'b0;
      end
      @(negedge clk);
      chk("done_pulse", {31'd0, bus.done}, 32'd1);
      chk("busy_clear", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
      chk("done_count", n_done - d0, 32'd1);
   endtask

   task automatic wait_done(output int t);
      bit seen = 0;
      t = 0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1;
            t = cyc;
         end
      end
      if (!seen) chk("done_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      vec_t vecs[8];
      exp_t e;
      int   t1, t2, d0;
      logic [15:0] ra, rb;
      logic rc;

      vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
      vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
      vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[6] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[7] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};

      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0;
      #12;
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_sum", {16'd0, bus.sum}, 32'd0);
      chk("rst_cout", {31'd0, bus.cout}, 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) begin
         e = '{vecs[i].sum, vecs[i].cout, vecs[i].ovf};
         do_add(vecs[i].a, vecs[i].b, vecs[i].cin, e, 1'b0);
      end

      for (int i = 0; i < 4; i++) begin
         ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
         do_add(ra, rb, rc, model(ra, rb, rc), 1'b0);
      end

      // Start during RUN must not disturb the op in flight.
      do_add(16'h4321, 16'h1111, 1'b0, '{16'h5432, 1'b0, 1'b0}, 1'b1);

      // Back-to-back with start held high.
      bus.a = 16'h0001; bus.b = 16'h0001; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      sb.push_back('{16'h0002, 1'b0, 1'b0});
      #1;
      bus.a = 16'h8000; bus.b = 16'h8000;
      wait_done(t1);
      @(posedge clk);
      sb.push_back('{16'h0000, 1'b1, 1'b1});
      #1;
      bus.start = 1'b0;
      wait_done(t2);
      chk("b2b_spacing", t2 - t1, 32'd5);
      @(negedge clk);

      // Reset during the 2nd RUN cycle discards the op.
      bus.a = 16'h1234; bus.b = 16'h1111; bus.cin = 1'b0; bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_sum", {16'd0, bus.sum}, 32'd0);
      chk("midrst_cout", {31'd0, bus.cout}, 32'd0);
      d0 = n_done;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) @(negedge clk);
      chk("midrst_no_done", n_done - d0, 32'd0);

      do_add(16'h0FF0, 16'h0011, 1'b1, '{16'h1002, 1'b0, 1'b0}, 1'b0);
      chk("sb_empty", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end
endmodule
